// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters.
// An optional sequencer zero-fills every word after reset before any grant.
//
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   req_i/we_i/addr_i/wdata_i/be_i   per-requester request bundle
//   gnt_o                       one-hot grant (combinational)
//   rvalid_o                    one-hot response, Latency cycles after grant
//   rdata_o                     read data broadcast, qualified by rvalid_o
//   init_done_o                 SRAM usable
//   sram_*                      single port towards the SRAM wrapper
module sram_port_arbiter #(
   parameter int unsigned NumReq    = 2,
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter bit          InitZero  = 1'b1,
   parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumReq-1:0]                   req_i,
   input  logic [NumReq-1:0]                   we_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
   input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
   output logic [NumReq-1:0]                   gnt_o,
   output logic [NumReq-1:0]                   rvalid_o,
   output logic [DataWidth-1:0]                rdata_o,
   output logic                                init_done_o,
   output logic                                sram_req_o,
   output logic                                sram_we_o,
   output logic [AddrWidth-1:0]                sram_addr_o,
   output logic [DataWidth-1:0]                sram_wdata_o,
   output logic [BeWidth-1:0]                  sram_be_o,
   input  logic [DataWidth-1:0]                sram_rdata_i
);

   localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic {INIT, RUN} state_e;
   localparam state_e ResetState = InitZero ? INIT : RUN;

   state_e                 state_q, state_d;
   logic [AddrWidth-1:0]   cnt_q, cnt_d;
   logic [IdxWidth-1:0]    ptr_q, ptr_d;
   logic                   done_q;
   logic                   run;
   logic                   found;
   logic                   grant;
   logic [IdxWidth-1:0]    win;
   int unsigned            scan;

   logic [Latency-1:0]                 vld_q;
   logic [Latency-1:0][IdxWidth-1:0]   pidx_q;

   // done_q also gates RUN so that nothing is granted before the first
   // edge after reset release when the zero-fill is skipped.
   assign run         = (state_q == RUN) && done_q;
   assign init_done_o = done_q;
   assign grant       = run && found;
   assign rdata_o     = sram_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ResetState;
         cnt_q   <= '0;
         ptr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         done_q  <= (state_d == RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AddrWidth'(NumWords - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
      endcase
   end

   // First asserted request at or after the pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      scan  = 0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         scan = (32'(ptr_q) + i) % NumReq;
         if (!found && req_i[IdxWidth'(scan)]) begin
            found = 1'b1;
            win   = IdxWidth'(scan);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      gnt_o = '0;
      if (grant) begin
         gnt_o = NumReq'(1) << win;
         ptr_d = IdxWidth'((32'(win) + 1) % NumReq);
      end
   end

   // The macro must see no access while reset is held.
   always_comb begin
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      if (state_q == INIT) begin
         sram_req_o  = rst_ni;
         sram_we_o   = 1'b1;
         sram_addr_o = cnt_q;
         sram_be_o   = '1;
      end else if (grant) begin
         sram_req_o   = 1'b1;
         sram_we_o    = we_i[win];
         sram_addr_o  = addr_i[win];
         sram_wdata_o = wdata_i[win];
         sram_be_o    = be_i[win];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q  <= '0;
         pidx_q <= '0;
      end else begin
         vld_q[0]  <= grant;
         pidx_q[0] <= win;
         for (int unsigned i = 1; i < Latency; i++) begin
            vld_q[i]  <= vld_q[i-1];
            pidx_q[i] <= pidx_q[i-1];
         end
      end
   end

   assign rvalid_o = vld_q[Latency-1] ?
                     (NumReq'(1) << pidx_q[Latency-1]) : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: init sweep, round-robin, RAW
// ordering, single-requester streaming, mid-run reset, no-init variant.
module tb_sram_port_arbiter;

   logic clk;
   logic rst_n;

   logic [1:0]        req;
   logic [1:0]        we;
   logic [1:0][3:0]   addr;
   logic [1:0][63:0]  wdata;
   logic [1:0][7:0]   be;

   logic [1:0]  gnt, rvalid;
   logic [63:0] rdata;
   logic        init_done;
   logic        s_req, s_we;
   logic [3:0]  s_addr;
   logic [63:0] s_wdata;
   logic [7:0]  s_be;
   logic [63:0] s_rdata;

   logic [1:0]  gnt_l2, rvalid_l2;
   logic [63:0] rdata_l2;
   logic        init_done_l2;
   logic        s_req_l2, s_we_l2;
   logic [3:0]  s_addr_l2;
   logic [63:0] s_wdata_l2;
   logic [7:0]  s_be_l2;

   logic [1:0]  req_nz;
   logic [1:0]  gnt_nz, rvalid_nz;
   logic [63:0] rdata_nz;
   logic        init_done_nz;
   logic        s_req_nz, s_we_nz;
   logic [3:0]  s_addr_nz;
   logic [63:0] s_wdata_nz;
   logic [7:0]  s_be_nz;

   logic [63:0] mem [0:15];

   int checks;
   int errors;

   sram_port_arbiter #(
      .NumReq(2), .NumWords(16), .DataWidth(64), .ByteWidth(8),
      .Latency(1), .InitZero(1'b1)
   ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .init_done_o(init_done),
      .sram_req_o(s_req), .sram_we_o(s_we), .sram_addr_o(s_addr),
      .sram_wdata_o(s_wdata), .sram_be_o(s_be), .sram_rdata_i(s_rdata)
   );

   sram_port_arbiter #(
      .NumReq(2), .NumWords(16), .DataWidth(64), .ByteWidth(8),
      .Latency(2), .InitZero(1'b1)
   ) u_l2 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt_l2), .rvalid_o(rvalid_l2), .rdata_o(rdata_l2),
      .init_done_o(init_done_l2),
      .sram_req_o(s_req_l2), .sram_we_o(s_we_l2), .sram_addr_o(s_addr_l2),
      .sram_wdata_o(s_wdata_l2), .sram_be_o(s_be_l2),
      .sram_rdata_i(64'h0)
   );

   sram_port_arbiter #(
      .NumReq(2), .NumWords(16), .DataWidth(64), .ByteWidth(8),
      .Latency(1), .InitZero(1'b0)
   ) u_nz (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req_nz), .we_i(2'b00), .addr_i(addr), .wdata_i(wdata),
      .be_i(be),
      .gnt_o(gnt_nz), .rvalid_o(rvalid_nz), .rdata_o(rdata_nz),
      .init_done_o(init_done_nz),
      .sram_req_o(s_req_nz), .sram_we_o(s_we_nz), .sram_addr_o(s_addr_nz),
      .sram_wdata_o(s_wdata_nz), .sram_be_o(s_be_nz),
      .sram_rdata_i(64'h0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latency-1 byte-enabled single-port SRAM.
   always @(posedge clk) begin
      if (s_req) begin
         if (s_we) begin
            for (int b = 0; b < 8; b++) begin
               if (s_be[b]) mem[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
            end
         end else begin
            s_rdata <= mem[s_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] e_g, e_v, e_v2;
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      req     = 2'b11;
      we      = 2'b00;
      addr[0] = 4'd3;
      addr[1] = 4'd7;
      wdata   = '0;
      be      = '1;
      req_nz  = 2'b01;

      @(posedge clk);
      @(negedge clk);
      chk("rst_init_done", 64'(init_done), 64'd0);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_sram_req", 64'(s_req), 64'd0);
      chk("rst_nz_done", 64'(init_done_nz), 64'd0);
      chk("rst_nz_gnt", 64'(gnt_nz), 64'd0);

      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("init_req", 64'(s_req), 64'd1);
         chk("init_we", 64'(s_we), 64'd1);
         chk("init_addr", 64'(s_addr), 64'(k));
         chk("init_wdata", s_wdata, 64'd0);
         chk("init_be", 64'(s_be), 64'hff);
         chk("init_gnt", 64'(gnt), 64'd0);
         chk("init_done_low", 64'(init_done), 64'd0);
         if (k == 0) begin
            chk("nz_done_pre", 64'(init_done_nz), 64'd0);
            chk("nz_gnt_pre", 64'(gnt_nz), 64'd0);
         end
         if (k == 1) begin
            chk("nz_done", 64'(init_done_nz), 64'd1);
            chk("nz_gnt", 64'(gnt_nz), 64'b01);
            @(posedge clk);
            #1 req_nz = 2'b00;
         end
         if (k == 2) begin
            chk("nz_rvalid", 64'(rvalid_nz), 64'b01);
            chk("nz_gnt_idle", 64'(gnt_nz), 64'd0);
         end
      end

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         e_g  = (i % 2 == 0) ? 2'b01 : 2'b10;
         e_v  = (i < 1) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
         e_v2 = (i < 2) ? 2'b00 : (((i - 2) % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_done", 64'(init_done), 64'd1);
         chk("rr_gnt", 64'(gnt), 64'(e_g));
         chk("rr_rvalid", 64'(rvalid), 64'(e_v));
         chk("rr_gnt_l2", 64'(gnt_l2), 64'(e_g));
         chk("rr_rvalid_l2", 64'(rvalid_l2), 64'(e_v2));
         chk("rr_addr", 64'(s_addr), (i % 2 == 0) ? 64'd3 : 64'd7);
         if (i > 0) chk("rr_rdata", rdata, 64'd0);
      end

      @(posedge clk);
      #1;
      req      = 2'b10;
      we       = 2'b10;
      addr[1]  = 4'd5;
      wdata[1] = 64'hDEADBEEF_CAFEF00D;
      be[1]    = 8'h0f;
      @(negedge clk);
      chk("wr_gnt", 64'(gnt), 64'b10);
      chk("wr_we", 64'(s_we), 64'd1);
      chk("wr_addr", 64'(s_addr), 64'd5);
      chk("wr_be", 64'(s_be), 64'h0f);
      chk("wr_wdata", s_wdata, 64'hDEADBEEF_CAFEF00D);

      @(posedge clk);
      #1;
      req     = 2'b01;
      we      = 2'b00;
      addr[0] = 4'd5;
      @(negedge clk);
      chk("rd_gnt", 64'(gnt), 64'b01);
      chk("rd_we", 64'(s_we), 64'd0);
      chk("wr_rvalid", 64'(rvalid), 64'b10);

      @(posedge clk);
      #1 req = 2'b00;
      @(negedge clk);
      chk("rd_rvalid", 64'(rvalid), 64'b01);
      chk("rd_rdata", rdata, 64'h00000000_CAFEF00D);
      chk("idle_gnt", 64'(gnt), 64'd0);
      chk("idle_sram_req", 64'(s_req), 64'd0);

      @(posedge clk);
      #1 req = 2'b10;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (i == 4) req = 2'b00;
         @(negedge clk);
         chk("solo_gnt", 64'(gnt), (i < 4) ? 64'b10 : 64'b00);
         chk("solo_rvalid", 64'(rvalid), (i == 0) ? 64'b00 : 64'b10);
         if (i > 0) chk("solo_rdata", rdata, 64'h00000000_CAFEF00D);
      end

      @(posedge clk);
      #1 req = 2'b01;
      @(negedge clk);
      chk("pre_rst_gnt", 64'(gnt), 64'b01);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req   = 2'b00;
      @(negedge clk);
      chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
      chk("mid_rst_rvalid_l2", 64'(rvalid_l2), 64'd0);
      chk("mid_rst_gnt", 64'(gnt), 64'd0);
      chk("mid_rst_done", 64'(init_done), 64'd0);
      chk("mid_rst_sram_req", 64'(s_req), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_rvalid_l2b", 64'(rvalid_l2), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reinit_req", 64'(s_req), 64'd1);
      chk("reinit_addr0", 64'(s_addr), 64'd0);
      chk("reinit_rvalid", 64'(rvalid), 64'd0);
      @(negedge clk);
      chk("reinit_addr1", 64'(s_addr), 64'd1);
      chk("reinit_done", 64'(init_done), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
